// File: rtl/pipe_controller_pkg.sv
// Shared types for the D/E/M/W control path: opcode map, ALU encodings,
// the per-stage control bundle and the branch-condition helper.
package pipe_ctrl_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_SHL  = 4'h5,
      OP_SHR  = 4'h6,
      OP_CMP  = 4'h7,
      OP_LDR  = 4'h8,
      OP_STR  = 4'h9,
      OP_MOVI = 4'hA,
      OP_OUT  = 4'hB,
      OP_B    = 4'hC,
      OP_BEQ  = 4'hD,
      OP_BLT  = 4'hE,
      OP_NOP  = 4'hF
   } opcode_e;

   localparam int ALU_W = 3;

   localparam logic [ALU_W-1:0] ALU_ADD   = 3'd0;
   localparam logic [ALU_W-1:0] ALU_SUB   = 3'd1;
   localparam logic [ALU_W-1:0] ALU_AND   = 3'd2;
   localparam logic [ALU_W-1:0] ALU_OR    = 3'd3;
   localparam logic [ALU_W-1:0] ALU_XOR   = 3'd4;
   localparam logic [ALU_W-1:0] ALU_SHL   = 3'd5;
   localparam logic [ALU_W-1:0] ALU_SHR   = 3'd6;
   localparam logic [ALU_W-1:0] ALU_PASSB = 3'd7;

   localparam logic [1:0] COND_AL = 2'b00;
   localparam logic [1:0] COND_EQ = 2'b01;
   localparam logic [1:0] COND_LT = 2'b10;

   typedef struct packed {
      logic             valid;
      logic             regwrite;
      logic             memwrite;
      logic             outio;
      logic             resultsel;
      logic             imm;
      logic             setflags;
      logic             branch;
      logic [1:0]       cond;
      logic [ALU_W-1:0] alu;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t BUBBLE = '0;

   // nzvc = {N,Z,V,C}
   function automatic logic cond_met(input logic [1:0] cond, input logic [3:0] nzvc);
      logic r;
      case (cond)
         COND_AL: r = 1'b1;
         COND_EQ: r = nzvc[2];
         COND_LT: r = nzvc[3] ^ nzvc[1];
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pipe_controller_if.sv
// Handshake bundle between the datapath/hazard unit (master) and the
// control path (slave).
interface pipe_controller_if #(
   parameter int OPCODEWIDTH  = 4,
   parameter int ALUCTRLWIDTH = 3
);
   logic [OPCODEWIDTH-1:0]  opcodeD;
   logic                    validD;
   logic                    stallE;
   logic [3:0]              flagsE;
   logic [ALUCTRLWIDTH-1:0] aluControlE;
   logic                    data2SelectorE;
   logic                    takeBranchE;
   logic                    flushFD;
   logic                    writeDataEnableM;
   logic                    outFlagIOM;
   logic                    writeEnableW;
   logic                    resultSelectorW;
   logic [3:0]              flagsQ;

   modport master (
      output opcodeD, validD, stallE, flagsE,
      input  aluControlE, data2SelectorE, takeBranchE, flushFD,
             writeDataEnableM, outFlagIOM, writeEnableW, resultSelectorW, flagsQ
   );

   modport slave (
      input  opcodeD, validD, stallE, flagsE,
      output aluControlE, data2SelectorE, takeBranchE, flushFD,
             writeDataEnableM, outFlagIOM, writeEnableW, resultSelectorW, flagsQ
   );
endinterface

// File: rtl/pipe_controller_ctrl_decoder.sv
// Combinational opcode -> control bundle. Opcodes with any bit set above
// the low nibble are treated as NOP.
module ctrl_decoder
   import pipe_ctrl_pkg::*;
#(
   parameter int OPCODEWIDTH = 4
) (
   input  logic [OPCODEWIDTH-1:0] opcode,
   input  logic                   valid,
   output ctrl_bundle_t           ctrl
);

   logic    hi_set;
   opcode_e op;

   if (OPCODEWIDTH > 4) begin : g_hi
      assign hi_set = |opcode[OPCODEWIDTH-1:4];
   end else begin : g_nohi
      assign hi_set = 1'b0;
   end

   always_comb begin
      op         = hi_set ? OP_NOP : opcode_e'(opcode[3:0]);
      ctrl       = BUBBLE;
      ctrl.valid = valid;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            ctrl.alu      = opcode[ALU_W-1:0];
            ctrl.regwrite = 1'b1;
            ctrl.setflags = 1'b1;
         end
         OP_CMP: begin
            ctrl.alu      = ALU_SUB;
            ctrl.setflags = 1'b1;
         end
         OP_LDR: begin
            ctrl.alu       = ALU_ADD;
            ctrl.imm       = 1'b1;
            ctrl.regwrite  = 1'b1;
            ctrl.resultsel = 1'b1;
         end
         OP_STR: begin
            ctrl.alu      = ALU_ADD;
            ctrl.imm      = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         OP_MOVI: begin
            ctrl.alu      = ALU_PASSB;
            ctrl.imm      = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         OP_OUT: begin
            ctrl.alu   = ALU_PASSB;
            ctrl.outio = 1'b1;
         end
         OP_B: begin
            ctrl.branch = 1'b1;
            ctrl.cond   = COND_AL;
         end
         OP_BEQ: begin
            ctrl.branch = 1'b1;
            ctrl.cond   = COND_EQ;
         end
         OP_BLT: begin
            ctrl.branch = 1'b1;
            ctrl.cond   = COND_LT;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pipe_controller.sv
// D/E/M/W control path: decode in D, control bundle carried through E,
// a MEM_STAGES-deep M chain and W; NZVC register and branch resolve in E.
module pipe_controller
   import pipe_ctrl_pkg::*;
#(
   parameter int OPCODEWIDTH  = 4,
   parameter int ALUCTRLWIDTH = 3,
   parameter int MEM_STAGES   = 1
) (
   input  logic              clk,
   input  logic              reset,
   pipe_controller_if.slave  pif
);

   ctrl_bundle_t dec;
   ctrl_bundle_t e_d;
   ctrl_bundle_t e_q;
   ctrl_bundle_t m_q [MEM_STAGES];
   ctrl_bundle_t m_last;
   ctrl_bundle_t w_q;
   logic [3:0]   flags_q;
   logic         take;

   ctrl_decoder #(.OPCODEWIDTH(OPCODEWIDTH)) u_dec (
      .opcode (pif.opcodeD),
      .valid  (pif.validD),
      .ctrl   (dec)
   );

   // Flags come from the register, so a branch right behind a CMP sees
   // the CMP result written at the edge that moved the branch into E.
   assign take = e_q.valid & e_q.branch & cond_met(e_q.cond, flags_q);

   assign e_d    = (!pif.validD || pif.stallE || take) ? BUBBLE : dec;
   assign m_last = m_q[MEM_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_q     <= BUBBLE;
         w_q     <= BUBBLE;
         flags_q <= '0;
         for (int i = 0; i < MEM_STAGES; i++) m_q[i] <= BUBBLE;
      end else begin
         e_q <= e_d;
         if (e_q.valid && e_q.setflags) flags_q <= pif.flagsE;
         m_q[0] <= e_q;
         for (int i = 1; i < MEM_STAGES; i++) m_q[i] <= m_q[i-1];
         w_q <= m_last;
      end
   end

   // Every strobe is qualified with its stage valid bit.
   assign pif.aluControlE      = e_q.valid ? ALUCTRLWIDTH'(e_q.alu) : '0;
   assign pif.data2SelectorE   = e_q.valid & e_q.imm;
   assign pif.takeBranchE      = take;
   assign pif.flushFD          = take;
   assign pif.writeDataEnableM = m_last.valid & m_last.memwrite;
   assign pif.outFlagIOM       = m_last.valid & m_last.outio;
   assign pif.writeEnableW     = w_q.valid & w_q.regwrite;
   assign pif.resultSelectorW  = w_q.valid & w_q.resultsel;
   assign pif.flagsQ           = flags_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Random + directed bench; two controllers (1 and 3 M stages) share stimulus
// and are compared against a cycle-scheduled instruction model.
module tb_pipe_controller;

   localparam int NCYC = 2048;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] op_d = '0;
   logic       vd_d = 1'b0;
   logic       st_d = 1'b0;
   logic [3:0] fl_d = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_controller_if #(.OPCODEWIDTH(4), .ALUCTRLWIDTH(3)) pif1 ();
   pipe_controller_if #(.OPCODEWIDTH(4), .ALUCTRLWIDTH(3)) pif3 ();

   assign pif1.opcodeD = op_d;
   assign pif1.validD  = vd_d;
   assign pif1.stallE  = st_d;
   assign pif1.flagsE  = fl_d;
   assign pif3.opcodeD = op_d;
   assign pif3.validD  = vd_d;
   assign pif3.stallE  = st_d;
   assign pif3.flagsE  = fl_d;

   pipe_controller #(.OPCODEWIDTH(4), .ALUCTRLWIDTH(3), .MEM_STAGES(1)) u_dut1 (
      .clk(clk), .reset(rst_n), .pif(pif1)
   );
   pipe_controller #(.OPCODEWIDTH(4), .ALUCTRLWIDTH(3), .MEM_STAGES(3)) u_dut3 (
      .clk(clk), .reset(rst_n), .pif(pif3)
   );

   // model: instruction currently in E (-1 = none), flags, and per-cycle
   // expected strobes for each M depth
   int         e_op;
   logic [3:0] m_flags;
   int         cyc;
   int         ms [2] = '{1, 3};
   bit         exp_mwr [2][NCYC];
   bit         exp_oio [2][NCYC];
   bit         exp_wen [2][NCYC];
   bit         exp_rs  [2][NCYC];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int alu_of(input int op);
      case (op)
         0, 1, 2, 3, 4, 5, 6: return op;  // ADD..SHR map straight through
         7:                   return 1;   // CMP subtracts
         8, 9:                return 0;   // address add
         10, 11:              return 7;   // pass B
         default:             return 0;
      endcase
   endfunction

   function automatic bit br_taken();
      if (e_op < 0) return 1'b0;
      case (e_op)
         12:      return 1'b1;
         13:      return m_flags[2];
         14:      return m_flags[3] ^ m_flags[1];
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_clear();
      e_op    = -1;
      m_flags = '0;
      for (int d = 0; d < 2; d++)
         for (int t = 0; t < NCYC; t++) begin
            exp_mwr[d][t] = 0; exp_oio[d][t] = 0; exp_wen[d][t] = 0; exp_rs[d][t] = 0;
         end
   endtask

   task automatic chk_dut(input string p, input int d, input logic [2:0] alu, input logic imm,
                          input logic tk, input logic fl, input logic wd, input logic oio,
                          input logic we, input logic rs, input logic [3:0] fq);
      bit tk_e;
      tk_e = br_taken();
      chk({p, ".alu"},   alu, (e_op >= 0) ? alu_of(e_op) : 0);
      chk({p, ".imm"},   imm, (e_op == 8 || e_op == 9 || e_op == 10));
      chk({p, ".take"},  tk,  tk_e);
      chk({p, ".flush"}, fl,  tk_e);
      chk({p, ".wdm"},   wd,  exp_mwr[d][cyc]);
      chk({p, ".oio"},   oio, exp_oio[d][cyc]);
      chk({p, ".wen"},   we,  exp_wen[d][cyc]);
      chk({p, ".rsel"},  rs,  exp_rs[d][cyc]);
      chk({p, ".flags"}, fq,  m_flags);
   endtask

   task automatic check_cycle();
      chk_dut("ms1", 0, pif1.aluControlE, pif1.data2SelectorE, pif1.takeBranchE, pif1.flushFD,
              pif1.writeDataEnableM, pif1.outFlagIOM, pif1.writeEnableW, pif1.resultSelectorW,
              pif1.flagsQ);
      chk_dut("ms3", 1, pif3.aluControlE, pif3.data2SelectorE, pif3.takeBranchE, pif3.flushFD,
              pif3.writeDataEnableM, pif3.outFlagIOM, pif3.writeEnableW, pif3.resultSelectorW,
              pif3.flagsQ);
   endtask

   task automatic chk_all_zero(input string p, input logic [2:0] alu, input logic imm,
                               input logic tk, input logic wd, input logic oio, input logic we,
                               input logic rs, input logic [3:0] fq);
      chk({p, ".rst_outs"}, {alu, imm, tk, wd, oio, we, rs}, '0);
      chk({p, ".rst_flags"}, fq, '0);
   endtask

   task automatic zero_check();
      chk_all_zero("ms1", pif1.aluControlE, pif1.data2SelectorE, pif1.takeBranchE,
                   pif1.writeDataEnableM, pif1.outFlagIOM, pif1.writeEnableW,
                   pif1.resultSelectorW, pif1.flagsQ);
      chk_all_zero("ms3", pif3.aluControlE, pif3.data2SelectorE, pif3.takeBranchE,
                   pif3.writeDataEnableM, pif3.outFlagIOM, pif3.writeEnableW,
                   pif3.resultSelectorW, pif3.flagsQ);
   endtask

   // Called at a negedge: drive inputs, advance model one edge, check.
   task automatic step(input int op, input bit vd, input bit st, input logic [3:0] fl);
      bit tk;
      int t;
      op_d = 4'(op); vd_d = vd; st_d = st; fl_d = fl;
      tk = br_taken();
      if (e_op >= 0 && e_op <= 7) m_flags = fl;
      if (vd && !st && !tk) begin
         e_op = op;
         t    = cyc + 1;
         for (int d = 0; d < 2; d++) begin
            exp_mwr[d][t + ms[d]]     = (op == 9);
            exp_oio[d][t + ms[d]]     = (op == 11);
            exp_wen[d][t + ms[d] + 1] = (op <= 6 || op == 8 || op == 10);
            exp_rs[d][t + ms[d] + 1]  = (op == 8);
         end
      end else begin
         e_op = -1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(15, 1'b0, 1'b0, 4'h0);
   endtask

   // Assert reset between edges, check the asynchronous clear, release.
   task automatic mid_reset();
      #2 rst_n = 1'b0;
      vd_d = 1'b0;
      #1 zero_check();
      model_clear();
      @(negedge clk);
      zero_check();
      rst_n = 1'b1;
      cyc   = 0;
      check_cycle();
   endtask

   initial begin
      model_clear();
      cyc = 0;
      repeat (3) @(negedge clk);
      zero_check();
      rst_n = 1'b1;
      check_cycle();

      // ADD through the pipe
      step(0, 1, 0, 4'h0);
      idle(5);
      // CMP Z=1, BEQ taken, follower killed
      step(7, 1, 0, 4'b0100);
      step(13, 1, 0, 4'h0);
      step(0, 1, 0, 4'h0);
      idle(5);
      // BLT taken (N=1,V=0), then not taken (N=1,V=1)
      step(7, 1, 0, 4'b1000);
      step(14, 1, 0, 4'h0);
      step(10, 1, 0, 4'h0);
      idle(5);
      step(7, 1, 0, 4'b1010);
      step(14, 1, 0, 4'h0);
      step(10, 1, 0, 4'h0);
      idle(5);
      // STR, stall bubble, LDR
      step(9, 1, 0, 4'h0);
      step(8, 1, 1, 4'h0);
      step(8, 1, 0, 4'h0);
      idle(6);
      // OUT
      step(11, 1, 0, 4'h0);
      idle(6);
      // LDR caught in M by reset
      step(8, 1, 0, 4'h0);
      step(15, 0, 0, 4'h0);
      mid_reset();
      idle(6);

      for (int i = 0; i < 700; i++) begin
         if (i == 350) mid_reset();
         step($urandom_range(0, 15), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 6) == 0), 4'($urandom_range(0, 15)));
      end
      idle(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
